// File: rtl/serv_wb_ram_resp_if.sv
// Wishbone data-bus bundle between the SERV load/store unit and the RAM responder.
// Signal names are seen from the responder side (i_ = into the RAM, o_ = out of it).
interface serv_wb_ram_resp_if;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_wb_err;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/serv_wb_ram_resp.sv
// Wishbone responder backed by a byte-lane RAM with programmable wait states.
// One access per request; ack/err pulse once, then hold until cyc drops.
module serv_wb_ram_resp #(
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 0,
    parameter bit ERR_EN = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst,
    serv_wb_ram_resp_if.slave wb
);
    localparam int NW = DEPTH / 4;
    localparam int AW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [29:0] word_q, word_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdt_q, rdt_d;

    logic [3:0][7:0] mem [NW];

    logic          in_range;
    logic          addr_ok;
    logic [29:0]   wrap;
    logic [AW-1:0] idx;
    logic          mem_we;
    logic          unused_ok;

    // Out-of-range words either fault or alias back into the array.
    assign in_range  = (word_q < 30'(NW));
    assign addr_ok   = in_range || !ERR_EN;
    assign wrap      = word_q % 30'(NW);
    assign idx       = wrap[AW-1:0];
    assign unused_ok = ^{wb.i_wb_adr[1:0], wrap[29:AW]};

    assign mem_we = (state_q == S_RESP) && wb.i_wb_cyc && addr_ok && we_q && !i_rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdt_d   = rdt_q;
        unique case (state_q)
            S_IDLE: begin
                if (wb.i_wb_cyc) begin
                    word_d  = wb.i_wb_adr[31:2];
                    dat_d   = wb.i_wb_dat;
                    sel_d   = wb.i_wb_sel;
                    we_d    = wb.i_wb_we;
                    cnt_d   = 8'(WAIT);
                    state_d = (WAIT > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!wb.i_wb_cyc) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!wb.i_wb_cyc) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                    if (addr_ok) begin
                        ack_d = 1'b1;
                        if (!we_q) rdt_d = mem[idx];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                // A lingering cyc after the response must not start a second access.
                if (!wb.i_wb_cyc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            word_q  <= 30'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdt_q   <= rdt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_q[n]) mem[idx][n] <= dat_q[8*n +: 8];
            end
        end
    end

    assign wb.o_wb_rdt = rdt_q;
    assign wb.o_wb_ack = ack_q;
    assign wb.o_wb_err = err_q;
endmodule

// File: tb/tb_serv_wb_ram_resp.sv
// Scoreboard bench for serv_wb_ram_resp: three instances cover WAIT=0/3 and ERR_EN=1/0.
// Drivers push expected responses; a negedge monitor pops and checks kind, data and cycle.
module tb_serv_wb_ram_resp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] adr [3];
    logic [31:0] dat [3];
    logic [3:0]  sel [3];
    logic        we  [3];
    logic        cyc [3];
    logic [31:0] rdt [3];
    logic        ack [3];
    logic        err [3];

    int waits [3] = '{0, 3, 0};

    serv_wb_ram_resp_if bus0 ();
    serv_wb_ram_resp_if bus1 ();
    serv_wb_ram_resp_if bus2 ();

    assign bus0.i_wb_adr = adr[0];
    assign bus0.i_wb_dat = dat[0];
    assign bus0.i_wb_sel = sel[0];
    assign bus0.i_wb_we  = we[0];
    assign bus0.i_wb_cyc = cyc[0];
    assign rdt[0] = bus0.o_wb_rdt;
    assign ack[0] = bus0.o_wb_ack;
    assign err[0] = bus0.o_wb_err;

    assign bus1.i_wb_adr = adr[1];
    assign bus1.i_wb_dat = dat[1];
    assign bus1.i_wb_sel = sel[1];
    assign bus1.i_wb_we  = we[1];
    assign bus1.i_wb_cyc = cyc[1];
    assign rdt[1] = bus1.o_wb_rdt;
    assign ack[1] = bus1.o_wb_ack;
    assign err[1] = bus1.o_wb_err;

    assign bus2.i_wb_adr = adr[2];
    assign bus2.i_wb_dat = dat[2];
    assign bus2.i_wb_sel = sel[2];
    assign bus2.i_wb_we  = we[2];
    assign bus2.i_wb_cyc = cyc[2];
    assign rdt[2] = bus2.o_wb_rdt;
    assign ack[2] = bus2.o_wb_ack;
    assign err[2] = bus2.o_wb_err;

    serv_wb_ram_resp #(.DEPTH(1024), .WAIT(0), .ERR_EN(1'b1)) dut0 (.i_clk(clk), .i_rst(rst), .wb(bus0.slave));
    serv_wb_ram_resp #(.DEPTH(1024), .WAIT(3), .ERR_EN(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .wb(bus1.slave));
    serv_wb_ram_resp #(.DEPTH(1024), .WAIT(0), .ERR_EN(1'b0)) dut2 (.i_clk(clk), .i_rst(rst), .wb(bus2.slave));

    typedef struct {
        int          dut;
        bit          err;
        logic [31:0] rdt;
        int          cyc;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every ack/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack[k] === 1'b1 || err[k] === 1'b1) begin
                chk("ack_err_exclusive", 32'(ack[k] & err[k]), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_response_dut", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_dut", 32'(k), 32'(e.dut));
                    chk("resp_is_err", 32'(err[k]), 32'(e.err));
                    chk("resp_rdt", rdt[k], e.rdt);
                    chk("resp_cycle", 32'(cyc_n), 32'(e.cyc));
                end
            end
        end
    end

    task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                        input logic w, input bit e_err, input logic [31:0] e_rdt, input int hold);
        exp_t e;
        bit   got;
        @(negedge clk);
        adr[d] = a; dat[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1;
        e.dut = d; e.err = e_err; e.rdt = e_rdt; e.cyc = cyc_n + waits[d] + 2;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (ack[d] === 1'b1) || (err[d] === 1'b1);
        end
        if (!got) begin
            chk("response_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_back());
        end
        if (hold > 0) begin
            // A different store held on the bus must be ignored while cyc never drops.
            dat[d] = ~wd; we[d] = 1'b1; sel[d] = 4'hF;
            repeat (hold) @(negedge clk);
        end
        cyc[d] = 1'b0;
    endtask

    task automatic abort_xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                              input int ncyc, input bit use_rst);
        @(negedge clk);
        adr[d] = a; dat[d] = wd; sel[d] = 4'hF; we[d] = 1'b1; cyc[d] = 1'b1;
        repeat (ncyc) @(negedge clk);
        cyc[d] = 1'b0;
        if (use_rst) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_mid_ack", 32'(ack[d]), 32'd0);
            chk("rst_mid_err", 32'(err[d]), 32'd0);
            chk("rst_mid_rdt", rdt[d], 32'd0);
            rst = 1'b0;
        end
        repeat (waits[d] + 4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            adr[k] = '0; dat[k] = '0; sel[k] = '0; we[k] = 1'b0; cyc[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ack", 32'(ack[k]), 32'd0);
            chk("reset_err", 32'(err[k]), 32'd0);
            chk("reset_rdt", rdt[k], 32'd0);
        end
        rst = 1'b0;

        // WAIT=0 store/load round trip
        xfer(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0,        0);
        xfer(0, 32'h10, 32'h0,        4'hF, 1'b0, 1'b0, 32'hDEADBEEF, 0);
        // Byte-lane merges, empty select, load ignores sel
        xfer(0, 32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF, 0);
        xfer(0, 32'h22, 32'h0000AA00, 4'h2, 1'b1, 1'b0, 32'hDEADBEEF, 0);
        xfer(0, 32'h20, 32'h0,        4'hF, 1'b0, 1'b0, 32'h1122AA44, 0);
        xfer(0, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'h1122AA44, 0);
        xfer(0, 32'h20, 32'h55000066, 4'h9, 1'b1, 1'b0, 32'h1122AA44, 0);
        xfer(0, 32'h20, 32'h0,        4'hF, 1'b0, 1'b0, 32'h5522AA66, 0);
        xfer(0, 32'h13, 32'h0,        4'h1, 1'b0, 1'b0, 32'hDEADBEEF, 0);
        // Range checking with ERR_EN=1
        xfer(0, 32'h0,   32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF, 0);
        xfer(0, 32'h400, 32'h0BADBAD0, 4'hF, 1'b1, 1'b1, 32'hDEADBEEF, 0);
        xfer(0, 32'h0,   32'h0,        4'hF, 1'b0, 1'b0, 32'hA5A5A5A5, 0);
        xfer(0, 32'h3FC, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'hA5A5A5A5, 0);
        xfer(0, 32'h3FC, 32'h0,        4'hF, 1'b0, 1'b0, 32'h12345678, 0);
        xfer(0, 32'hFFFFFFF0, 32'h0,   4'hF, 1'b0, 1'b1, 32'h12345678, 0);
        // Wrapping with ERR_EN=0
        xfer(2, 32'h0,   32'h11111111, 4'hF, 1'b1, 1'b0, 32'h0,        0);
        xfer(2, 32'h400, 32'h22222222, 4'hF, 1'b1, 1'b0, 32'h0,        0);
        xfer(2, 32'h0,   32'h0,        4'hF, 1'b0, 1'b0, 32'h22222222, 0);
        xfer(2, 32'h800, 32'h0,        4'hF, 1'b0, 1'b0, 32'h22222222, 0);
        // Stale cyc held for 4 cycles after ack
        xfer(0, 32'h30, 32'h0F0F0F0F, 4'hF, 1'b1, 1'b0, 32'h12345678, 4);
        xfer(0, 32'h30, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0F0F0F0F, 0);
        // WAIT=3 latency and abort in the second wait cycle
        xfer(1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0,        0);
        xfer(1, 32'h40, 32'h0,        4'hF, 1'b0, 1'b0, 32'hCAFEF00D, 0);
        abort_xfer(1, 32'h40, 32'h12345678, 2, 1'b0);
        xfer(1, 32'h40, 32'h0,        4'hF, 1'b0, 1'b0, 32'hCAFEF00D, 0);
        // Reset during the wait phase of a store
        xfer(1, 32'h44, 32'h77777777, 4'hF, 1'b1, 1'b0, 32'hCAFEF00D, 0);
        abort_xfer(1, 32'h44, 32'h88888888, 2, 1'b1);
        xfer(1, 32'h44, 32'h0,        4'hF, 1'b0, 1'b0, 32'h77777777, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
